ece571f23_g5_aes_sbox_arbiter: RTL and testbench

ECE571F23_G5_AES_SBOX_ARBITER -- requirements
Module: ece571f23_g5_aes_sbox_arbiter

---
 rtl/ece571f23_g5_aes_pkg.sv | 53 +++++
 rtl/ece571f23_g5_aes_sbox.sv | 12 +
 rtl/ece571f23_g5_aes_sbox_arbiter.sv | 124 ++++++++++++
 tb/tb_ece571f23_g5_aes_sbox_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ece571f23_g5_aes_pkg.sv
// Shared types and constants for the AES S-box arbiter slice.
// The S-box is a GF(2^8) inverse followed by the AES affine map.
package ece571f23_g5_aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KX,
    ST_SB,
    ST_DONE
  } state_e;

  typedef enum logic {
    CL_KX,
    CL_SB
  } client_e;

  localparam int KX_BYTES = 4;
  localparam int SB_BYTES = 16;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    // a^254 = a^-1, and 0 maps to 0
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

endpackage

// File: rtl/ece571f23_g5_aes_sbox.sv
// Single shared AES S-box lookup, one byte per cycle.
// Purely combinational; the arbiter registers the result.
module ece571f23_g5_aes_sbox
  import ece571f23_g5_aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = sbox_f(in_byte);

endmodule

// File: rtl/ece571f23_g5_aes_sbox_arbiter.sv
// Round-robin arbiter sharing one S-box between key expansion
// (4-byte SubWord) and the round datapath (16-byte SubBytes).
module ece571f23_g5_aes_sbox_arbiter
  import ece571f23_g5_aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kx_req,
  input  logic [31:0]  kx_word,
  output logic         kx_ack,
  output logic [31:0]  kx_result,
  input  logic         sb_req,
  input  logic [127:0] sb_state,
  output logic         sb_ack,
  output logic [127:0] sb_result,
  output logic         busy
);

  localparam logic [3:0] KX_LAST = 4'(KX_BYTES - 1);
  localparam logic [3:0] SB_LAST = 4'(SB_BYTES - 1);

  state_e         state_q, state_d;
  client_e        last_q, last_d;
  client_e        cur_q, cur_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;
  logic [31:0]    kx_res_q, kx_res_d;
  logic [127:0]   sb_res_q, sb_res_d;
  logic           kx_ack_q, kx_ack_d;
  logic           sb_ack_q, sb_ack_d;
  logic [7:0]     sbox_in;
  logic [7:0]     sbox_out;

  assign sbox_in = work_q[{cnt_q, 3'b000} +: 8];

  ece571f23_g5_aes_sbox u_sbox (
    .in_byte  (sbox_in),
    .out_byte (sbox_out)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    kx_res_d = kx_res_q;
    sb_res_d = sb_res_q;
    kx_ack_d = 1'b0;
    sb_ack_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (kx_req && (!sb_req || last_q == CL_SB)) begin
          state_d = ST_KX;
          cur_d   = CL_KX;
          work_d  = {96'h0, kx_word};
          cnt_d   = 4'd0;
        end else if (sb_req) begin
          state_d = ST_SB;
          cur_d   = CL_SB;
          work_d  = sb_state;
          cnt_d   = 4'd0;
        end
      end
      ST_KX: begin
        kx_res_d[{cnt_q[1:0], 3'b000} +: 8] = sbox_out;
        if (cnt_q == KX_LAST) begin
          state_d  = ST_DONE;
          kx_ack_d = 1'b1;
          cnt_d    = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SB: begin
        sb_res_d[{cnt_q, 3'b000} +: 8] = sbox_out;
        if (cnt_q == SB_LAST) begin
          state_d  = ST_DONE;
          sb_ack_d = 1'b1;
          cnt_d    = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = cur_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ack is raised on the edge entering DONE so it spans the DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= CL_SB;
      cur_q    <= CL_KX;
      cnt_q    <= 4'd0;
      work_q   <= '0;
      kx_res_q <= '0;
      sb_res_q <= '0;
      kx_ack_q <= 1'b0;
      sb_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      kx_res_q <= kx_res_d;
      sb_res_q <= sb_res_d;
      kx_ack_q <= kx_ack_d;
      sb_ack_q <= sb_ack_d;
    end
  end

  assign kx_ack    = kx_ack_q;
  assign sb_ack    = sb_ack_q;
  assign kx_result = kx_res_q;
  assign sb_result = sb_res_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ece571f23_g5_aes_sbox_arbiter.sv
// Directed bench for the shared S-box arbiter.
// Expected S-box bytes are taken from the published AES table.
module tb_ece571f23_g5_aes_sbox_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         kx_req;
  logic [31:0]  kx_word;
  logic         kx_ack;
  logic [31:0]  kx_result;
  logic         sb_req;
  logic [127:0] sb_state;
  logic         sb_ack;
  logic [127:0] sb_result;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;
  int both_ack = 0;

  localparam logic [127:0] ALL63 = {16{8'h63}};
  localparam logic [127:0] SEQ_IN = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] SEQ_OUT = 128'h76abd7fe2b670130c56f6bf27b777c63;

  ece571f23_g5_aes_sbox_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kx_req    (kx_req),
    .kx_word   (kx_word),
    .kx_ack    (kx_ack),
    .kx_result (kx_result),
    .sb_req    (sb_req),
    .sb_state  (sb_state),
    .sb_ack    (sb_ack),
    .sb_result (sb_result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (kx_ack && sb_ack) both_ack++;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_until(
    input  bit sel_sb,
    input  int max,
    output int n,
    output int bsy
  );
    n   = 0;
    bsy = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (busy) bsy++;
    end while (!(sel_sb ? sb_ack : kx_ack) && n <= max);
  endtask

  int n;
  int bsy;

  initial begin
    rst_n    = 1'b0;
    kx_req   = 1'b0;
    sb_req   = 1'b0;
    kx_word  = '0;
    sb_state = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_kx_ack", 128'(kx_ack), 128'(0));
    check("rst_sb_ack", 128'(sb_ack), 128'(0));
    check("rst_kx_res", 128'(kx_result), 128'(0));
    check("rst_sb_res", sb_result, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // single SubWord
    kx_word = 32'hff530100;
    kx_req  = 1'b1;
    run_until(1'b0, 30, n, bsy);
    kx_req = 1'b0;
    check("kx_lat", 128'(n), 128'(5));
    check("kx_res", 128'(kx_result), 128'h16ed7c63);
    check("kx_busy_ack", 128'(busy), 128'(1));
    @(negedge clk);
    check("kx_ack_pulse", 128'(kx_ack), 128'(0));
    check("kx_idle", 128'(busy), 128'(0));

    // SubBytes with request dropped after grant
    sb_state = '0;
    sb_req   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb_req = 1'b0;
    bsy = 0;
    run_until(1'b1, 40, n, bsy);
    check("sb_lat", 128'(n + 1), 128'(17));
    check("sb_busy_cnt", 128'(bsy + 1), 128'(17));
    check("sb_res", sb_result, ALL63);
    check("sb_kx_hold", 128'(kx_result), 128'h16ed7c63);
    @(negedge clk);
    check("sb_ack_pulse", 128'(sb_ack), 128'(0));

    // tie after reset: KX first, then SB, then KX again
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_kx_res", 128'(kx_result), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    kx_word  = 32'hff530100;
    sb_state = SEQ_IN;
    kx_req   = 1'b1;
    sb_req   = 1'b1;
    run_until(1'b0, 30, n, bsy);
    check("tie_kx_lat", 128'(n), 128'(5));
    check("tie_kx_res", 128'(kx_result), 128'h16ed7c63);
    kx_word = 32'h13121110;
    run_until(1'b1, 40, n, bsy);
    check("tie_sb_lat", 128'(n + 5), 128'(23));
    check("tie_sb_res", sb_result, SEQ_OUT);
    check("tie_kx_hold", 128'(kx_result), 128'h16ed7c63);
    sb_req = 1'b0;
    run_until(1'b0, 30, n, bsy);
    kx_req = 1'b0;
    check("regrant_kx_lat", 128'(n), 128'(6));
    check("regrant_kx_res", 128'(kx_result), 128'h7dc982ca);
    check("regrant_sb_hold", sb_result, SEQ_OUT);
    @(negedge clk);

    // reset while SB is on byte 8
    sb_state = '0;
    sb_req   = 1'b1;
    repeat (9) @(negedge clk);
    check("mid_busy", 128'(busy), 128'(1));
    rst_n  = 1'b0;
    sb_req = 1'b0;
    #1;
    check("mid_rst_res", sb_result, 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bsy = 0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (sb_ack || busy) n++;
    end
    check("mid_no_ack", 128'(n), 128'(0));
    check("mid_res_zero", sb_result, 128'(0));
    check("no_dual_ack", 128'(both_ack), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
